// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 3x4 keypad scanner.
// Contents: matrix dimensions, '*'/'#' key codes, debounce FSM state
// encodings and the (row, col) -> key code map.
package keypad_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', 0, '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bundle.
//   KEY_ROW   row sense lines from the matrix (asynchronous)
//   KEY_COL   one-hot column strobes to the matrix
//   key_code  last accepted key code
//   key_valid one-cycle new-key pulse
//   key_held  key currently held down
// slave: the scanner; master: the matrix/consumer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] KEY_ROW;
    logic [NUM_COLS-1:0] KEY_COL;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    modport master (output KEY_ROW, input KEY_COL, key_code, key_valid, key_held);
    modport slave  (input KEY_ROW, output KEY_COL, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Frame-level debounce for the keypad scanner. Consumes one frame result
// per scan frame and produces the debounced key event outputs.
//   clk_2, rst   clock, synchronous active-high reset
//   frame_end    one-cycle strobe: frame result below is valid
//   frame_empty  no key, or a multi-key ghost, in this frame
//   frame_code   code of the single key seen this frame
//   key_code / key_valid / key_held  debounced key outputs
// Macro KEYPAD_REPEAT_EN adds auto-repeat pulses while a key stays held.
//
// state    | meaning
// IDLE     | no key held, waiting for a single-key frame
// DEBOUNCE | candidate key seen, counting matching frames
// PRESSED  | key accepted and reported, waiting for empty frames
// RELEASE  | empty frames seen, counting toward release
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_SCANS = 50
`endif
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic       frame_end,
    input  logic       frame_empty,
    input  logic [3:0] frame_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic           SINGLE   = (DEBOUNCE_SCANS == 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic          rep_fire;

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = rep_fire;
        held_d  = held_q;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (!frame_empty) begin
                        cand_d = frame_code;
                        if (SINGLE) begin
                            state_d = ST_PRESSED;
                            code_d  = frame_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_empty) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (frame_code == cand_q) begin
                        if (cnt_q >= CNT_LAST) begin
                            state_d = ST_PRESSED;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (frame_empty) begin
                        if (SINGLE) begin
                            state_d = ST_IDLE;
                            held_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                default: begin
                    if (frame_empty) begin
                        if (cnt_q >= CNT_LAST) begin
                            state_d = ST_IDLE;
                            held_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        // Bounce during release: the key was never let go.
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int             RW       = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_SCANS - 1);

    logic [RW-1:0] rep_q, rep_d;

    always_ff @(posedge clk_2) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end

    // Any frame that is not "PRESSED with the reported key" clears the count,
    // which also covers the clear on entry to PRESSED.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (frame_end) begin
            if (state_q == ST_PRESSED && !frame_empty && frame_code == code_q) begin
                if (rep_q >= REP_LAST) begin
                    rep_fire = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end else begin
                rep_d = '0;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad matrix scanner: strobes columns one-hot, synchronises and
// samples the rows, reduces each full scan frame to a single-key result
// (ghost combinations read as empty) and debounces it into key events.
//   clk_2  system clock
//   rst    synchronous active-high reset
//   kp     keypad_scanner_if.slave (KEY_ROW in, KEY_COL/key_code/key_valid/key_held out)
// Macro KEYPAD_REPEAT_EN enables auto-repeat every REPEAT_SCANS frames.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic           clk_2,
    input  logic           rst,
    keypad_scanner_if.slave kp
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] row_meta_q, row_meta_d;
    logic [NUM_ROWS-1:0] row_sync_q, row_sync_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          acc_hits_q, acc_hits_d;
    logic [3:0]          acc_code_q, acc_code_d;

    logic                sample;
    logic                frame_end;
    logic                frame_empty;
    logic [3:0]          frame_code;
    logic [2:0]          col_hits;
    logic [2:0]          hit_sum;
    logic [3:0]          col_code;
    logic [NUM_COLS-1:0] col_oh;

    always_ff @(posedge clk_2) begin
        if (rst) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
            dwell_q    <= '0;
            col_q      <= '0;
            acc_hits_q <= '0;
            acc_code_q <= '0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            dwell_q    <= dwell_d;
            col_q      <= col_d;
            acc_hits_q <= acc_hits_d;
            acc_code_q <= acc_code_d;
        end
    end

    always_comb begin
        row_meta_d = kp.KEY_ROW;
        row_sync_d = row_meta_q;

        // Sampling on the last dwell cycle leaves SCAN_DIV-1 cycles for the
        // strobe to settle through the matrix and the two sync flops.
        sample  = (dwell_q == DWELL_LAST);
        dwell_d = sample ? '0 : dwell_q + 1'b1;
        col_d   = col_q;
        if (sample) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

        col_hits = '0;
        col_code = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_sync_q[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_map(2'(r), col_q);
            end
        end

        hit_sum     = {1'b0, acc_hits_q} + col_hits;
        frame_end   = sample && (col_q == 2'd2);
        frame_code  = (col_hits != 3'd0) ? col_code : acc_code_q;
        frame_empty = (hit_sum != 3'd1);

        // Hit count saturates at 2: anything beyond one hit is a ghost.
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_hits_d = '0;
            acc_code_d = '0;
        end else if (sample) begin
            acc_hits_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            acc_code_d = frame_code;
        end

        case (col_q)
            2'd0:    col_oh = 3'b001;
            2'd1:    col_oh = 3'b010;
            default: col_oh = 3'b100;
        endcase
    end

    assign kp.KEY_COL = col_oh;

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_SCANS (REPEAT_SCANS)
`endif
    ) u_debounce (
        .clk_2       (clk_2),
        .rst         (rst),
        .frame_end   (frame_end),
        .frame_empty (frame_empty),
        .frame_code  (frame_code),
        .key_code    (kp.key_code),
        .key_valid   (kp.key_valid),
        .key_held    (kp.key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DS    = 2;
    localparam int RS    = 3;
    localparam int FRAME = 3 * SD;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic        clk_2 = 1'b0;
    logic        rst;
    logic [11:0] mask;
    logic [3:0]  row_drv;
    logic        chk_en;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
        .clk_2 (clk_2),
        .rst   (rst),
        .kp    (kp)
    );

    always #5 clk_2 = ~clk_2;

    // Matrix model: row r reads high when a pressed key in that row sits on the strobed column.
    always_comb begin
        row_drv = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (mask[r*3+c] && kp.KEY_COL[c]) row_drv[r] = 1'b1;
    end
    assign kp.KEY_ROW = row_drv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int         t;
    logic [2:0] exp_col;
    logic       exp_valid, exp_held;
    logic [3:0] exp_code;
    int         run_key, run_len, empty_run, rep;
    event       frame_done;

    always @(posedge clk_2) begin
        int hits, fc;
        if (rst) begin
            t = 0; exp_col = 3'b001; exp_valid = 0; exp_code = 0; exp_held = 0;
            run_key = 0; run_len = 0; empty_run = 0; rep = 0;
        end else begin
            exp_valid = 0;
            if (t % FRAME == FRAME - 1) begin
                hits = $countones(mask);
                fc = 0;
                for (int i = 0; i < 12; i++) if (mask[i]) fc = code_tab[i];
                if (!exp_held) begin
                    if (hits == 1) begin
                        run_len = (run_len > 0 && run_key == fc) ? run_len + 1 : 1;
                        run_key = fc;
                        if (run_len >= DS) begin
                            exp_valid = 1; exp_code = 4'(fc); exp_held = 1;
                            rep = 0; empty_run = 0; run_len = 0;
                        end
                    end else run_len = 0;
                end else if (hits == 1) begin
                    if (empty_run > 0) rep = 0;
                    else if (fc == int'(exp_code)) begin
                        rep++;
                        if (REP_ON != 0 && rep == RS) begin exp_valid = 1; rep = 0; end
                    end else rep = 0;
                    empty_run = 0;
                end else begin
                    empty_run++;
                    if (empty_run >= DS) begin exp_held = 0; empty_run = 0; run_len = 0; end
                end
                -> frame_done;
            end
            t++;
            exp_col = 3'b001 << ((t / SD) % 3);
        end
    end

    always @(negedge clk_2) begin
        if (chk_en) begin
            chk("key_col", 32'(kp.KEY_COL), 32'(exp_col));
            chk("key_valid", 32'(kp.key_valid), 32'(exp_valid));
            chk("key_code", 32'(kp.key_code), 32'(exp_code));
            chk("key_held", 32'(kp.key_held), 32'(exp_held));
            if (!rst && kp.key_valid) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frames(input int n);
        repeat (n) @(frame_done);
        #1;
    endtask

    task automatic hold(input logic [11:0] m, input int n);
        mask = m;
        wait_frames(n);
    endtask

    task automatic settle_and_sync();
        @(negedge clk_2);
        #1;
    endtask

    task automatic press_release(input int bit_idx, input int exp_c, input string nm);
        pulses = 0;
        hold(12'(1) << bit_idx, 3);
        chk({nm, "_code"}, 32'(kp.key_code), 32'(exp_c));
        hold('0, 2);
        settle_and_sync();
        chk({nm, "_pulses"}, 32'(pulses), 32'd1);
        wait_frames(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mask = '0; rst = 1'b1; chk_en = 1'b0;
        repeat (2) @(posedge clk_2);
        #1 chk_en = 1'b1;
        chk("rst_col", 32'(kp.KEY_COL), 32'b001);
        chk("rst_valid", 32'(kp.key_valid), 32'd0);
        chk("rst_held", 32'(kp.key_held), 32'd0);
        rst = 1'b0;
        @(negedge clk_2); chk("col_t0", 32'(kp.KEY_COL), 32'b001);
        repeat (4) @(negedge clk_2); chk("col_t4", 32'(kp.KEY_COL), 32'b010);
        repeat (4) @(negedge clk_2); chk("col_t8", 32'(kp.KEY_COL), 32'b100);
        repeat (4) @(negedge clk_2); chk("col_t12", 32'(kp.KEY_COL), 32'b001);
        wait_frames(1);

        // (r3,c1) held 5 frames, then two empty frames release it.
        pulses = 0;
        hold(12'(1) << 10, 5);
        chk("hold0_code", 32'(kp.key_code), 32'd0);
        chk("hold0_held", 32'(kp.key_held), 32'd1);
        hold('0, 1);
        chk("hold0_held_1empty", 32'(kp.key_held), 32'd1);
        hold('0, 1);
        chk("hold0_released", 32'(kp.key_held), 32'd0);
        settle_and_sync();
        chk("hold0_pulses", 32'(pulses), REP_ON ? 32'd2 : 32'd1);
        wait_frames(1);

        press_release(1, 2, "key2");
        press_release(11, 11, "keyhash");
        press_release(9, 10, "keystar");

        // Single-frame blip and a two-key ghost must both stay silent.
        pulses = 0;
        hold(12'(1) << 4, 1);
        hold('0, 2);
        hold((12'(1) << 4) | (12'(1) << 8), 4);
        hold('0, 2);
        settle_and_sync();
        chk("blip_ghost_pulses", 32'(pulses), 32'd0);
        wait_frames(1);

        // (r0,c0) held with a one-frame ghost from (r2,c2), then reset mid-hold.
        pulses = 0;
        hold(12'(1), 3);
        hold(12'(1) | (12'(1) << 8), 1);
        hold(12'(1), 2);
        chk("ghost_hold_pulses", 32'(pulses), 32'd1);
        rst = 1'b1;
        @(posedge clk_2); @(posedge clk_2); #1;
        chk("midrst_held", 32'(kp.key_held), 32'd0);
        chk("midrst_code", 32'(kp.key_code), 32'd0);
        rst = 1'b0;
        pulses = 0;
        wait_frames(2);
        chk("postrst_code", 32'(kp.key_code), 32'd1);
        chk("postrst_held", 32'(kp.key_held), 32'd1);
        hold('0, 2);
        settle_and_sync();
        chk("postrst_pulses", 32'(pulses), 32'd1);
        wait_frames(1);

        // (r2,c1) held 10 frames: repeats at +3 and +6 frames when enabled.
        pulses = 0;
        hold(12'(1) << 7, 10);
        chk("rep_code", 32'(kp.key_code), 32'd8);
        hold('0, 2);
        settle_and_sync();
        chk("rep_pulses", 32'(pulses), REP_ON ? 32'd3 : 32'd1);
        wait_frames(1);

        // Randomised key traffic checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [11:0] m;
            kind = $urandom_range(0, 9);
            m = '0;
            if (kind >= 3) m[$urandom_range(0, 11)] = 1'b1;
            if (kind == 9) m[$urandom_range(0, 11)] = 1'b1;
            hold(m, $urandom_range(1, 4));
        end
        hold('0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
